regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and per-port decode structs for the multi-ported register file.
// Both structs are width-independent so they stay valid for any DATA_W / NUM_REGS.
package regfile_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefNumRegs = 32;
  localparam int unsigned DefNumRd   = 2;
  localparam int unsigned DefNumWr   = 2;
  localparam int unsigned DefRegRead = 0;

  // Write ports are limited to two, so one bit selects the winning port.
  localparam int unsigned WrIdxW = 1;

  // Write-port decode: live = enabled write to a nonzero register,
  // shadowed = a higher-index port writes the same register this cycle.
  typedef struct packed {
    logic live;
    logic shadowed;
  } wr_ctl_t;

  // Read-port bypass selection: which write port, if any, forwards its data.
  typedef struct packed {
    logic              hit;
    logic [WrIdxW-1:0] port;
  } rd_sel_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: allocs set, writes clear, and a same-cycle alloc wins.
// Queries return the post-edge view, so the update takes effect in the same cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned NUM_WR   = DefNumWr,
  parameter int unsigned NUM_Q    = DefNumRd,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_alloc_en,
  input  logic [AW-1:0]             i_alloc_addr,
  input  logic [NUM_WR-1:0]         i_clr_en,
  input  logic [NUM_WR-1:0][AW-1:0] i_clr_addr,
  input  logic [NUM_Q-1:0][AW-1:0]  i_query_addr,
  output logic [NUM_Q-1:0]          o_pending
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (i_clr_en[p]) begin
        pend_d[i_clr_addr[p]] = 1'b0;
      end
    end
    if (i_alloc_en) begin
      pend_d[i_alloc_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar q = 0; q < NUM_Q; q++) begin : g_query
    assign o_pending[q] = !i_reset && pend_d[i_query_addr[q]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with write-to-read bypass, optional registered reads
// with hold, and a pending-producer scoreboard. Register 0 is hardwired to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter int unsigned NUM_WR   = DefNumWr,
  parameter int unsigned REG_READ = DefRegRead,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_RD-1:0][AW-1:0]     i_rs_addr,
  input  logic                          i_rd_hold,
  input  logic [NUM_WR-1:0]             i_wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     i_wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] i_wr_data,
  input  logic                          i_alloc_en,
  input  logic [AW-1:0]                 i_alloc_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]             o_rs_pending
);

  wr_ctl_t [NUM_WR-1:0] wr_ctl;
  logic    [DATA_W-1:0] regs_q [NUM_REGS];

  always_comb begin
    wr_ctl = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      wr_ctl[p].live = i_wr_en[p] && (i_wr_addr[p] != '0);
      for (int q = p + 1; q < int'(NUM_WR); q++) begin
        if (i_wr_en[q] && (i_wr_addr[q] == i_wr_addr[p])) begin
          wr_ctl[p].shadowed = 1'b1;
        end
      end
    end
  end

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if (wr_ctl[p].live && !wr_ctl[p].shadowed) begin
          regs_q[i_wr_addr[p]] <= i_wr_data[p];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .NUM_Q    (NUM_RD)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_addr (i_alloc_addr),
    .i_clr_en     (i_wr_en),
    .i_clr_addr   (i_wr_addr),
    .i_query_addr (i_rs_addr),
    .o_pending    (o_rs_pending)
  );

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]     look_addr;
    rd_sel_t           sel;
    logic [DATA_W-1:0] byp_data;

    // Ascending scan leaves the highest-index matching write port selected.
    always_comb begin
      sel = '0;
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if (wr_ctl[p].live && (i_wr_addr[p] == look_addr)) begin
          sel.hit  = 1'b1;
          sel.port = WrIdxW'(p);
        end
      end
    end

    assign byp_data = sel.hit ? i_wr_data[sel.port] : regs_q[look_addr];

    if (REG_READ != 0) begin : g_reg
      logic [AW-1:0]     addr_q;
      logic [DATA_W-1:0] data_q;

      // While held, the captured address keeps tracking writes through the bypass.
      assign look_addr = i_rd_hold ? addr_q : i_rs_addr[r];

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          addr_q <= '0;
          data_q <= '0;
        end else begin
          addr_q <= look_addr;
          data_q <= byp_data;
        end
      end

      assign o_rs_data[r] = data_q;
    end else begin : g_comb
      assign look_addr    = i_rs_addr[r];
      assign o_rs_data[r] = i_reset ? '0 : byp_data;
    end
  end

  if (REG_READ == 0) begin : g_no_hold
    logic unused_hold;
    assign unused_hold = i_rd_hold;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Drives one combinational-read and one registered-read instance from shared stimulus
// and scores both against an array-level model through an expectation queue.
module tb_regfile_mp;

  typedef struct packed {
    logic [1:0][31:0] d0;
    logic [1:0][31:0] d1;
    logic [1:0]       p;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][4:0]  rs_addr;
  logic             hold;
  logic [1:0]       wen;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  logic             aen;
  logic [4:0]       aa;
  logic [1:0][31:0] d0;
  logic [1:0][31:0] d1;
  logic [1:0]       p0;
  logic [1:0]       p1;

  logic [31:0]      m_regs [32];
  logic             m_pend [32];
  logic [1:0][31:0] m_rq;
  logic [1:0][4:0]  m_ra;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .REG_READ (0)
  ) u_comb (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rs_addr    (rs_addr),
    .i_rd_hold    (hold),
    .i_wr_en      (wen),
    .i_wr_addr    (wa),
    .i_wr_data    (wd),
    .i_alloc_en   (aen),
    .i_alloc_addr (aa),
    .o_rs_data    (d0),
    .o_rs_pending (p0)
  );

  regfile_mp #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .REG_READ (1)
  ) u_reg (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rs_addr    (rs_addr),
    .i_rd_hold    (hold),
    .i_wr_en      (wen),
    .i_wr_addr    (wa),
    .i_wr_data    (wd),
    .i_alloc_en   (aen),
    .i_alloc_addr (aa),
    .o_rs_data    (d1),
    .o_rs_pending (p1)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s[%0d] cycle=%0d actual=0x%08h required=0x%08h",
               name, idx, cyc, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_rq = '0;
    m_ra = '0;
  endtask

  // One clock of stimulus: expectation is the register/pending state as it will
  // stand after this edge; registered reads show last cycle's captured result.
  task automatic step(input logic r, input logic [1:0] en, input logic [4:0] a0,
                      input logic [31:0] v0, input logic [4:0] a1, input logic [31:0] v1,
                      input logic al, input logic [4:0] al_addr, input logic [4:0] ra0,
                      input logic [4:0] ra1, input logic h);
    logic [31:0] nregs [32];
    logic        npend [32];
    exp_t        e;
    e = '0;
    @(negedge clk);
    rst = r; wen = en; wa[0] = a0; wd[0] = v0; wa[1] = a1; wd[1] = v1;
    aen = al; aa = al_addr; rs_addr[0] = ra0; rs_addr[1] = ra1; hold = h;
    cyc++;
    if (r) begin
      model_clear();
    end else begin
      nregs = m_regs;
      npend = m_pend;
      for (int p = 0; p < 2; p++) begin
        if (wen[p] && wa[p] != 5'd0) nregs[wa[p]] = wd[p];
        if (wen[p]) npend[wa[p]] = 1'b0;
      end
      if (aen) npend[aa] = 1'b1;
      npend[0] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e.d0[k] = nregs[rs_addr[k]];
        e.p[k]  = npend[rs_addr[k]];
        e.d1[k] = m_rq[k];
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      m_regs = nregs;
      m_pend = npend;
      for (int k = 0; k < 2; k++) begin
        if (!h) m_ra[k] = rs_addr[k];
        m_rq[k] = nregs[m_ra[k]];
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 2; k++) begin
          chk("comb_data", k, d0[k], e.d0[k]);
          chk("reg_data", k, d1[k], e.d1[k]);
          chk("comb_pend", k, {31'd0, p0[k]}, {31'd0, e.p[k]});
          chk("reg_pend", k, {31'd0, p1[k]}, {31'd0, e.p[k]});
        end
      end
    end
  end

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin : driver
    rst = 1'b1; wen = '0; wa = '0; wd = '0; aen = 1'b0; aa = '0; rs_addr = '0; hold = 1'b0;
    model_clear();
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2'b11, 3, 32'h1, 4, 32'h2, 1, 3, 3, 4, 0);
    // x5 written on port0 while port1 reads it, then read back from the array
    step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 0);
    // both ports write x7; port1 must win
    step(0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 7, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 5, 0);
    // x0 stays zero and never pending
    step(0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 0);
    step(0, 2'b10, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 7, 0);
    // pending lifecycle on x3
    step(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    step(0, 2'b01, 3, 32'h44, 0, 0, 1, 3, 3, 3, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    step(0, 2'b10, 0, 0, 3, 32'h55, 0, 0, 3, 3, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    // held registered read of x9 tracks a write to x9 but not to x10
    step(0, 2'b01, 9, 32'h1, 0, 0, 0, 0, 9, 9, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 0);
    step(0, 2'b01, 9, 32'h2, 0, 0, 0, 0, 4, 5, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 5, 1);
    step(0, 2'b10, 0, 0, 10, 32'h77, 0, 0, 10, 10, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 10, 9, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 10, 9, 0);
    // reset asserted mid-traffic, then reads after release
    step(0, 2'b11, 12, 32'hABCD, 13, 32'h1234, 1, 14, 12, 13, 0);
    step(1, 2'b11, 12, 32'h9999, 13, 32'h8888, 1, 12, 12, 13, 0);
    step(1, 2'b11, 5, 32'h9999, 7, 32'h8888, 1, 5, 5, 7, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 12, 14, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 7, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 3, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), 2'($urandom_range(0, 3)), rnd_addr(), $urandom,
           rnd_addr(), $urandom, ($urandom_range(0, 2) == 0), rnd_addr(), rnd_addr(),
           rnd_addr(), ($urandom_range(0, 3) == 0));
    end
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
